// File: rtl/key_event_ctrl.sv
// key_event_ctrl: turns PS/2 scan-code bytes into make/break events, moves the
// display cursor, writes printable characters to the display and queues their
// ASCII codes for the UART transmitter.
module key_event_ctrl #(
    parameter int unsigned DIGITS     = 8,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned AUTO_ADV   = 1,
    parameter int unsigned REPEAT_EN  = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] code_byte,
    input  logic       code_valid,
    output logic [7:0] conv_code,
    input  logic [7:0] ascii_in,
    output logic       disp_we,
    output logic [2:0] disp_idx,
    output logic [7:0] disp_char,
    output logic [2:0] cursor,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       overflow
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [2:0]  CUR_LAST = 3'(DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXT,
        S_BRK,
        S_EXT_BRK
    } state_t;

    state_t      state_q, state_d;
    logic        is_make, is_break, ev_ext;
    logic [8:0]  ev_key;
    logic        key_match, make_pass;

    logic [8:0]  held;
    logic        held_valid;
    logic        act_valid, act_ext;

    logic        do_write, push;
    logic [7:0]  wr_char, push_data;
    logic [2:0]  cursor_d;

    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;
    logic        full, pop, push_ok;

    // Prefix state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Prefix decode: next state and make/break event classification
    always_comb begin
        state_d  = state_q;
        is_make  = 1'b0;
        is_break = 1'b0;
        ev_ext   = 1'b0;
        if (code_valid) begin
            case (state_q)
                S_IDLE: begin
                    if (code_byte == 8'hE0)      state_d = S_EXT;
                    else if (code_byte == 8'hF0) state_d = S_BRK;
                    else                         is_make = 1'b1;
                end
                S_EXT: begin
                    if (code_byte == 8'hF0) state_d = S_EXT_BRK;
                    else begin
                        is_make = 1'b1;
                        ev_ext  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                S_BRK: begin
                    is_break = 1'b1;
                    state_d  = S_IDLE;
                end
                S_EXT_BRK: begin
                    is_break = 1'b1;
                    ev_ext   = 1'b1;
                    state_d  = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
        ev_key    = {ev_ext, code_byte};
        key_match = held_valid && (ev_key == held);
        make_pass = is_make && !(key_match && (REPEAT_EN == 0));
    end

    // Held-key tracking and the event stage feeding the action stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held       <= '0;
            held_valid <= 1'b0;
            act_valid  <= 1'b0;
            act_ext    <= 1'b0;
            conv_code  <= '0;
        end else begin
            act_valid <= make_pass;
            act_ext   <= ev_ext;
            if (make_pass) begin
                held       <= ev_key;
                held_valid <= 1'b1;
                conv_code  <= code_byte;
            end else if (is_break && key_match) begin
                held_valid <= 1'b0;
            end
        end
    end

    // Action decode: cursor movement, display write and queue push
    always_comb begin
        do_write  = 1'b0;
        push      = 1'b0;
        wr_char   = '0;
        push_data = '0;
        cursor_d  = cursor;
        if (act_valid && !act_ext) begin
            case (conv_code)
                8'h6B: if (cursor != CUR_LAST) cursor_d = cursor + 3'd1;
                8'h74: if (cursor != 3'd0)     cursor_d = cursor - 3'd1;
                8'h66: begin
                    do_write  = 1'b1;
                    wr_char   = 8'h20;
                    push      = 1'b1;
                    push_data = 8'h08;
                end
                default: begin
                    if (ascii_in != 8'h00) begin
                        do_write  = 1'b1;
                        wr_char   = ascii_in;
                        push      = 1'b1;
                        push_data = ascii_in;
                        if ((AUTO_ADV != 0) && (cursor != 3'd0))
                            cursor_d = cursor - 3'd1;
                    end
                end
            endcase
        end
    end

    // Display write strobe, held index/char, and cursor register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_we   <= 1'b0;
            disp_idx  <= '0;
            disp_char <= '0;
            cursor    <= CUR_LAST;
        end else begin
            disp_we <= do_write;
            cursor  <= cursor_d;
            if (do_write) begin
                disp_idx  <= cursor;
                disp_char <= wr_char;
            end
        end
    end

    assign full     = (count == (AW+1)'(FIFO_DEPTH));
    assign tx_valid = (count != '0);
    assign pop      = tx_valid && tx_ready;
    // When full, a simultaneous pop frees the head slot that wr_ptr points at
    assign push_ok  = push && (!full || pop);
    assign tx_data  = tx_valid ? mem[rd_ptr] : '0;

    // Queue storage
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

    // Queue pointers, occupancy and sticky overflow flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop)      count <= count + 1'b1;
            else if (!push_ok && pop) count <= count - 1'b1;
            if (push && !push_ok) overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_key_event_ctrl.sv
// Directed self-checking bench for key_event_ctrl.
module tb_key_event_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] code_byte = '0;
    logic       code_valid = 1'b0;
    logic [7:0] conv_code;
    logic [7:0] ascii_in;
    logic       disp_we;
    logic [2:0] disp_idx;
    logic [7:0] disp_char;
    logic [2:0] cursor;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b0;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    int         wr_count = 0;
    logic [2:0] last_idx = '0;
    logic [7:0] last_char = '0;
    logic [7:0] popq [$];

    key_event_ctrl #(
        .DIGITS(8), .FIFO_DEPTH(8), .AUTO_ADV(1), .REPEAT_EN(0)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .code_byte(code_byte), .code_valid(code_valid),
        .conv_code(conv_code), .ascii_in(ascii_in),
        .disp_we(disp_we), .disp_idx(disp_idx), .disp_char(disp_char),
        .cursor(cursor),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Stand-in for the external scan-code to ASCII table
    always_comb begin
        case (conv_code)
            8'h1C: ascii_in = 8'h41;
            8'h32: ascii_in = 8'h42;
            8'h21: ascii_in = 8'h43;
            8'h23: ascii_in = 8'h44;
            8'h24: ascii_in = 8'h45;
            8'h2B: ascii_in = 8'h46;
            8'h34: ascii_in = 8'h47;
            8'h33: ascii_in = 8'h48;
            8'h43: ascii_in = 8'h49;
            default: ascii_in = 8'h00;
        endcase
    end

    // Display-write and UART-pop observers
    always @(posedge clk) begin
        if (!rst_n) wr_count = 0;
        else if (disp_we) begin
            wr_count++;
            last_idx  = disp_idx;
            last_char = disp_char;
        end
        if (rst_n && tx_valid && tx_ready) popq.push_back(tx_data);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        code_byte  = b;
        code_valid = 1'b1;
        @(negedge clk);
        code_valid = 1'b0;
    endtask

    task automatic press(input logic [7:0] b);
        send(b);
        send(8'hF0);
        send(b);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n      = 1'b0;
        code_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drain(input int n);
        @(negedge clk);
        tx_ready = 1'b1;
        idle(n);
        tx_ready = 1'b0;
        idle(1);
    endtask

    logic [7:0] exp_bytes [8];
    logic [7:0] held_data;

    initial begin
        // T1: reset values, then one printable press
        idle(2);
        rst_n = 1'b1;
        idle(1);
        check("rst_conv_code", conv_code, 8'h00);
        check("rst_disp_we", disp_we, 1'b0);
        check("rst_disp_idx", disp_idx, 3'd0);
        check("rst_disp_char", disp_char, 8'h00);
        check("rst_cursor", cursor, 3'd7);
        check("rst_tx_valid", tx_valid, 1'b0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_overflow", overflow, 1'b0);

        press(8'h1C);
        idle(3);
        check("t1_writes", wr_count, 1);
        check("t1_idx", last_idx, 3'd7);
        check("t1_char", last_char, 8'h41);
        check("t1_cursor", cursor, 3'd6);
        check("t1_tx_valid", tx_valid, 1'b1);
        check("t1_tx_data", tx_data, 8'h41);
        check("t1_disp_we_low", disp_we, 1'b0);

        // T2: typematic repeats suppressed, release then press again
        send(8'h1C); send(8'h1C); send(8'h1C);
        idle(3);
        check("t2_repeat_writes", wr_count, 2);
        check("t2_repeat_idx", last_idx, 3'd6);
        check("t2_repeat_cursor", cursor, 3'd5);
        send(8'hF0); send(8'h1C); send(8'h1C);
        idle(3);
        check("t2_second_writes", wr_count, 3);
        check("t2_second_idx", last_idx, 3'd5);
        check("t2_second_cursor", cursor, 3'd4);
        popq.delete();
        drain(8);
        check("t2_pop_count", popq.size(), 3);
        for (int i = 0; i < 3; i++)
            if (i < popq.size()) check("t2_pop_data", popq[i], 8'h41);
        check("t2_empty", tx_valid, 1'b0);

        // T3: extended keypad codes ignored, plain KP_4 saturates at 7
        send(8'hE0); send(8'h6B);
        send(8'hE0); send(8'hF0); send(8'h6B);
        idle(3);
        check("t3_ext_cursor", cursor, 3'd4);
        check("t3_ext_writes", wr_count, 3);
        press(8'h6B);
        idle(3);
        check("t3_kp4_step", cursor, 3'd5);
        for (int i = 0; i < 3; i++) press(8'h6B);
        idle(3);
        check("t3_kp4_sat", cursor, 3'd7);
        check("t3_no_push", tx_valid, 1'b0);

        // T4: KP_6 to digit 0, overwrite at 0, backspace
        for (int i = 0; i < 8; i++) press(8'h74);
        idle(3);
        check("t4_cursor0", cursor, 3'd0);
        press(8'h32);
        idle(3);
        check("t4_b_writes", wr_count, 4);
        check("t4_b_idx", last_idx, 3'd0);
        check("t4_b_char", last_char, 8'h42);
        check("t4_b_cursor", cursor, 3'd0);
        press(8'h1C);
        idle(3);
        check("t4_a_idx", last_idx, 3'd0);
        check("t4_a_char", last_char, 8'h41);
        press(8'h66);
        idle(3);
        check("t4_bksp_writes", wr_count, 6);
        check("t4_bksp_idx", last_idx, 3'd0);
        check("t4_bksp_char", last_char, 8'h20);
        check("t4_bksp_cursor", cursor, 3'd0);
        popq.delete();
        drain(6);
        check("t4_pop_count", popq.size(), 3);
        if (popq.size() == 3) begin
            check("t4_pop0", popq[0], 8'h42);
            check("t4_pop1", popq[1], 8'h41);
            check("t4_pop2", popq[2], 8'h08);
        end

        // T5: nine back-to-back printable makes into an 8-deep queue
        popq.delete();
        @(negedge clk);
        code_valid = 1'b1;
        code_byte = 8'h1C; @(negedge clk);
        code_byte = 8'h32; @(negedge clk);
        code_byte = 8'h21; @(negedge clk);
        code_byte = 8'h23; @(negedge clk);
        code_byte = 8'h24; @(negedge clk);
        code_byte = 8'h2B; @(negedge clk);
        code_byte = 8'h34; @(negedge clk);
        code_byte = 8'h33; @(negedge clk);
        code_byte = 8'h43; @(negedge clk);
        code_valid = 1'b0;
        idle(3);
        check("t5_overflow", overflow, 1'b1);
        check("t5_tx_valid", tx_valid, 1'b1);
        check("t5_head", tx_data, 8'h41);
        check("t5_no_pop", popq.size(), 0);
        held_data = tx_data;
        idle(4);
        check("t5_stable", tx_data, held_data);
        exp_bytes = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48};
        drain(12);
        check("t5_pop_count", popq.size(), 8);
        for (int i = 0; i < 8; i++)
            if (i < popq.size()) check("t5_pop_order", popq[i], exp_bytes[i]);
        check("t5_sticky", overflow, 1'b1);
        check("t5_empty", tx_valid, 1'b0);

        // T6: reset between break prefix and code discards the break
        send(8'hF0);
        do_reset();
        check("t6_overflow_clr", overflow, 1'b0);
        check("t6_cursor_rst", cursor, 3'd7);
        send(8'h1C);
        idle(3);
        check("t6_writes", wr_count, 1);
        check("t6_idx", last_idx, 3'd7);
        check("t6_char", last_char, 8'h41);
        check("t6_cursor", cursor, 3'd6);
        check("t6_head", tx_data, 8'h41);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
